// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants used by the decode/operand stage.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_SUB_SRA = 7'b0100000;

endpackage

// File: rtl/regfile.sv
// 32-entry register file: two async read ports with write-through bypass,
// one synchronous write port, x0 hardwired to zero.
module regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [32];

  // Storage: cleared on reset; reset has priority so no write lands during it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end

  // Reads: x0 is zero, a same-cycle writeback to the read index is forwarded.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : ((we && wa == ra1) ? wd : mem[ra1]);
    rd2 = (ra2 == 5'd0) ? '0 : ((we && wa == ra2) ? wd : mem[ra2]);
  end

endmodule

// File: rtl/id_stage.sv
// Decode/operand stage feeding the registered ALU: decodes RV32I ALU-class
// ops, reads operands, tracks pending writes with a busy scoreboard and
// holds the decoded op in a single output register.
module id_stage import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic            alu_imm,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            illegal
);

  // ALU add-vs-sub / arithmetic-shift select; only R-type ADD/SUB looks at bit 30.
  function automatic logic imm_sel(input logic is_r, input logic [2:0] f3, input logic b30);
    case (f3)
      F3_ADD:  return !(is_r && b30);
      F3_SR:   return b30;
      default: return 1'b0;
    endcase
  endfunction

  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] f3;
  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign f3  = in_instr[14:12];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];

  logic [XLEN-1:0] rs1_val, rs2_val;

  regfile #(.XLEN(XLEN)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (wb_en),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  logic signed [XLEN-1:0] imm_i;
  logic        [XLEN-1:0] imm_u;
  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_u = {in_instr[31:12], 12'b0};

  logic [XLEN-1:0] x_d, y_d;
  logic [2:0]      f3_d;
  logic [6:0]      f7_d;
  logic            imm_d, we_d, ill_d, use1, use2;
  logic [4:0]      rd_d;

  // Decode: operand selection and ALU controls; unsupported opcodes yield zeros.
  always_comb begin
    x_d   = '0;
    y_d   = '0;
    f3_d  = '0;
    f7_d  = '0;
    imm_d = 1'b0;
    rd_d  = '0;
    we_d  = 1'b0;
    ill_d = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    case (opc)
      OPC_OP: begin
        x_d = rs1_val; y_d = rs2_val; f3_d = f3; f7_d = in_instr[31:25];
        imm_d = imm_sel(1'b1, f3, in_instr[30]);
        rd_d = rd; we_d = 1'b1; use1 = 1'b1; use2 = 1'b1;
      end
      OPC_OP_IMM: begin
        x_d = rs1_val; y_d = imm_i; f3_d = f3;
        imm_d = imm_sel(1'b0, f3, in_instr[30]);
        rd_d = rd; we_d = 1'b1; use1 = 1'b1;
      end
      OPC_LUI: begin
        y_d = imm_u; f3_d = F3_ADD; imm_d = 1'b1; rd_d = rd; we_d = 1'b1;
      end
      OPC_AUIPC: begin
        x_d = in_pc; y_d = imm_u; f3_d = F3_ADD; imm_d = 1'b1; rd_d = rd; we_d = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
  end

  // Scoreboard: bit 0 is never set, so x0 never stalls.
  logic [31:0] busy, clr, set, pend;
  logic        hazard, acc, vld_p1;

  // Clear vector from writeback and the bits still pending after it.
  always_comb begin
    clr = '0;
    if (wb_en) clr[wb_rd] = 1'b1;
    pend = busy & ~clr;
  end

  assign hazard   = (use1 && pend[rs1]) || (use2 && pend[rs2]) || (we_d && pend[rd]);
  assign in_ready = (!vld_p1 || out_ready) && !hazard;
  assign acc      = in_valid && in_ready;

  // Set vector for the destination of an accepted writing op.
  always_comb begin
    set = '0;
    if (acc && we_d && rd != 5'd0) set[rd] = 1'b1;
  end

  // Busy register: set wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr) | set;
  end

  // ---- p0 -> p1: output register ----
  logic [XLEN-1:0] x_p1, y_p1;
  logic [2:0]      f3_p1;
  logic [6:0]      f7_p1;
  logic            imm_p1, we_p1, ill_p1;
  logic [4:0]      rd_p1;

  // Output register: load on accept, hold under backpressure, drop when consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
      f3_p1  <= '0;
      f7_p1  <= '0;
      imm_p1 <= 1'b0;
      rd_p1  <= '0;
      we_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (acc) begin
      vld_p1 <= 1'b1;
      x_p1   <= x_d;
      y_p1   <= y_d;
      f3_p1  <= f3_d;
      f7_p1  <= f7_d;
      imm_p1 <= imm_d;
      rd_p1  <= rd_d;
      we_p1  <= we_d;
      ill_p1 <= ill_d;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign alu_x      = x_p1;
  assign alu_y      = y_p1;
  assign alu_funct3 = f3_p1;
  assign alu_funct7 = f7_p1;
  assign alu_imm    = imm_p1;
  assign out_rd     = rd_p1;
  assign out_we     = we_p1;
  assign illegal    = ill_p1;

endmodule

// File: doc/id_stage.md
# id_stage

Decode/operand stage that sits directly upstream of the registered integer ALU. It accepts one 32-bit RV32I instruction per handshake and reads rs1/rs2 from an internal register file that has a writeback port. It then presents registered ALU operands and controls (`x`, `y`, `funct3`, `funct7`, `imm`) plus the destination register. A per-register busy scoreboard stalls read-after-write and write-after-write hazards until the matching writeback arrives.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage accepts this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of `in_instr`.
- `wb_en`  in  1  register writeback strobe.
- `wb_rd`  in  5  writeback register index.
- `wb_data`  in  32  writeback value.
- `out_valid`  out  1  decoded op held.
- `out_ready`  in  1  downstream (ALU issue) accepts.
- `alu_x`, `alu_y`  out  32  ALU operands.
- `alu_funct3`  out  3  ALU op select.
- `alu_funct7`  out  7  ALU funct7.
- `alu_imm`  out  1  ALU add-vs-sub / arithmetic-shift select.
- `out_rd`  out  5  destination register.
- `out_we`  out  1  result must be written back.
- `illegal`  out  1  unsupported opcode.

## Operation
- **Accept:** `in_valid && in_ready`. `in_ready = (!out_valid || out_ready) && !hazard`. `in_ready` may depend combinationally on `in_instr`.
- **Supported opcodes:**
  - OP (0110011): `x`=rs1, `y`=rs2, `funct7`=instr[31:25].
  - OP-IMM (0010011): `x`=rs1, `y`=sign-extended instr[31:20], `funct7`=0.
  - LUI (0110111): `x`=0, `y`={instr[31:12],12'b0}, `funct3`=000, `imm`=1.
  - AUIPC (0010111): `x`=`in_pc`, `y`=U-immediate, `funct3`=000, `imm`=1.
- **`alu_funct3`:** equals instr[14:12] for OP and OP-IMM.
- **`alu_imm` encoding**, matching the ALU:
  - funct3 000: 1, except OP with instr[30]=1 (SUB), which gives 0.
  - funct3 101: instr[30] (1 = SRA/SRAI).
  - Otherwise: 0.
- **Other opcodes:** `illegal`=1, `out_we`=0, operands and `out_rd` are 0, no scoreboard update. They still complete the handshake.
- **Register file:**
  - 32×32, x0 reads 0, writes to x0 are ignored.
  - Write-through bypass: if `wb_en && wb_rd==rs && rs!=0`, the read returns `wb_data` in the same cycle.
- **Scoreboard:**
  - `busy[31:1]`. Set `busy[rd]` on accept when `out_we && rd!=0`. Clear on `wb_en` for `wb_rd`.
  - If set and clear hit the same index in the same cycle, set wins.
- **Hazard:** a used rs1/rs2 (x0 excluded), or a written rd, is busy and not being cleared by `wb_en` this cycle.
  - LUI ignores rs1/rs2.
  - AUIPC uses no sources.
  - OP-IMM uses rs1 only.

## Timing
- Latency: accept in cycle N, outputs valid from cycle N+1. Throughput is 1 per cycle while `out_ready`=1 and there is no hazard.
- **Output register:** loads on accept. It holds stable while `out_valid && !out_ready`. `out_valid` clears when the op is consumed and nothing new is accepted.
- **Reset:**
  - `out_valid`, `alu_*`, `out_rd`, `out_we`, `illegal` = 0.
  - `busy` = 0, register file = 0.
  - `in_ready` = 1 in the first cycle after reset (absent a hazard).
- **Reset during a stall or a held output:** all in-flight state is discarded, with no partial writes.
- **Writeback and read of the same register in one cycle:** the read sees the new data, and the stall releases in that same cycle.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants `OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`;
  - funct3 ALU codes (ADD … AND);
  - `F7_SUB_SRA` = 7'b0100000.
- Sub-module `regfile`: 2 async read ports, 1 synchronous write port, bypass, x0 hardwired.
- Decode, scoreboard and output register stay in `id_stage`.

## Test plan
- **ADDI x1,x0,5 (0x00500093):**
  - Stimulus: offered after reset.
  - Response one cycle later: `alu_x`=0, `alu_y`=5, `funct3`=000, `funct7`=0, `imm`=1, `out_rd`=1, `out_we`=1.
- **SUB x3,x1,x2 (0x402081B3):**
  - Stimulus: after writebacks x1=7, x2=2.
  - Response: `x`=7, `y`=2, `funct7`=0x20, `imm`=0.
- **SRAI x5,x1,3 (0x4030D293):**
  - Response: `funct3`=101, `imm`=1, `y`=0x403, `funct7`=0.
- **RAW hazard:**
  - Stimulus: ADDI x1 issued, then ADD x2,x1,x1 (0x00108133) offered.
  - Response: `in_ready`=0 until `wb_en`,`wb_rd`=1,`wb_data`=5, at which point it is accepted with `x`=`y`=5.
- **Backpressure:**
  - Stimulus: `out_ready`=0 for 3 cycles.
  - Response: outputs bit-stable, `in_ready`=0, nothing is lost.
  - Follow-on: release, then two back-to-back ops issue on consecutive cycles.
- **Illegal and reset:**
  - Stimulus: instr 0x00000000.
  - Response: `illegal`=1, `out_we`=0, scoreboard unchanged.
  - Follow-on: `rst` during a hazard stall leaves `busy` clear and `out_valid`=0 next cycle.
